// File: rtl/minibyte_periph.sv
// minibyte_periph: an 8-byte memory-mapped window on the minibyte CPU bus.
// It holds a GPIO output latch, a synchronised GPIO input and an 8-bit timer
// with a reloadable prescaler, sticky MATCH/OVF flags and a level irq.
`timescale 1ns/1ps
module minibyte_periph #(
  parameter logic [7:0] BASE_ADDR   = 8'hF8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] addr_in,
  input  logic [7:0] data_in,
  input  logic       we_in,
  output logic       sel_out,
  output logic [7:0] rd_data_out,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic       irq_out
);

  // Register state
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] gpio_q, cnt_q, cmp_q, pre_q, pc_q;
  logic [3:0] ctl_q;
  logic       match_q, ovf_q, irq_q;

  // Next-state values
  logic [7:0] gpio_d, cnt_d, cmp_d, pre_d, pc_d;
  logic [3:0] ctl_d;
  logic       match_d, ovf_d, irq_d;

  // Decode helpers
  logic [2:0] off;
  logic       wr_hit;
  logic       run, tick, tmr_tick, hit, set_match, set_ovf;

  assign sel_out = (addr_in[7:3] == BASE_ADDR[7:3]);
  assign off     = addr_in[2:0];
  assign wr_hit  = we_in & sel_out;

  assign gpio_out = gpio_q;
  assign irq_out  = irq_q;

  // Combinational read mux; anything outside the window reads as zero
  always_comb begin
    rd_data_out = 8'h00;
    if (sel_out) begin
      case (off)
        3'd0:    rd_data_out = gpio_q;
        3'd1:    rd_data_out = sync_q[SYNC_STAGES-1];
        3'd2:    rd_data_out = cnt_q;
        3'd3:    rd_data_out = cmp_q;
        3'd4:    rd_data_out = pre_q;
        3'd5:    rd_data_out = {4'h0, ctl_q};
        3'd6:    rd_data_out = {6'h00, ovf_q, match_q};
        default: rd_data_out = 8'h00;
      endcase
    end
  end

  // Next-state logic: CPU writes, prescaler, timer and sticky flags
  always_comb begin
    gpio_d = (wr_hit && off == 3'd0) ? data_in : gpio_q;
    cmp_d  = (wr_hit && off == 3'd3) ? data_in : cmp_q;
    pre_d  = (wr_hit && off == 3'd4) ? data_in : pre_q;
    ctl_d  = (wr_hit && off == 3'd5) ? data_in[3:0] : ctl_q;

    // A write clearing EN kills a tick due on the same edge; enabling only
    // starts counting from the following edge (pc was held at PRE).
    run  = ctl_q[0] & ctl_d[0];
    tick = run & (pc_q == 8'h00);

    if (wr_hit && off == 3'd4)  pc_d = data_in;
    else if (!run)              pc_d = pre_q;
    else if (pc_q == 8'h00)     pc_d = pre_q;
    else                        pc_d = pc_q - 8'd1;

    // A CPU write to the count swallows a coincident tick entirely
    tmr_tick  = tick & ~(wr_hit && off == 3'd2);
    hit       = (cnt_q == cmp_q);
    set_match = tmr_tick & hit;
    set_ovf   = tmr_tick & ~(hit & ctl_q[1]) & (cnt_q == 8'hFF);

    if (wr_hit && off == 3'd2)       cnt_d = data_in;
    else if (tmr_tick && hit && ctl_q[1]) cnt_d = 8'h00;
    else if (tmr_tick)               cnt_d = cnt_q + 8'd1;
    else                             cnt_d = cnt_q;

    // Hardware set beats a simultaneous write-one-to-clear
    match_d = (match_q & ~(wr_hit && off == 3'd6 && data_in[0])) | set_match;
    ovf_d   = (ovf_q   & ~(wr_hit && off == 3'd6 && data_in[1])) | set_ovf;

    irq_d = (match_d & ctl_d[2]) | (ovf_d & ctl_d[3]);
  end

  // Register bank with asynchronous reset
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      gpio_q  <= 8'h00;
      cnt_q   <= 8'h00;
      cmp_q   <= 8'hFF;
      pre_q   <= 8'h00;
      pc_q    <= 8'h00;
      ctl_q   <= 4'h0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      gpio_q  <= gpio_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      pre_q   <= pre_d;
      pc_q    <= pc_d;
      ctl_q   <= ctl_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
    end
  end

  // GPIO input synchroniser chain, stage 0 samples the pins
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
  end

endmodule
